// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one 512-bit block, 64 rounds at one round per clock.
// Define SHA256_FEEDFWD_EN to add the H feed-forward; otherwise digest is the raw a..h.
module sha256_compress (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    input  logic [31:0]  k_in,
    output logic [5:0]   t,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    // Handshake: start is taken only in IDLE (busy low); busy stays high through FINAL,
    // done pulses for one cycle with digest already valid, and a start in that cycle is accepted.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   rnd_q, rnd_d;
    logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0]  a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [255:0] digest_q, digest_d;
    logic         done_q, done_d;
`ifdef SHA256_FEEDFWD_EN
    logic [255:0] hreg_q, hreg_d;
`endif

    logic [31:0]  t1, t2, w_next;

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // k_in arrives one cycle after t, so it already holds K[rnd] for the current round.
    assign t1     = h_q + bsig1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + k_in + w_q[0];
    assign t2     = bsig0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
    assign w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ROUND;
            S_ROUND: if (rnd_q == 6'd63) state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rnd_d    = rnd_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        e_d      = e_q;
        f_d      = f_q;
        g_d      = g_q;
        h_d      = h_q;
        w_d      = w_q;
        digest_d = digest_q;
        done_d   = 1'b0;
`ifdef SHA256_FEEDFWD_EN
        hreg_d   = hreg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rnd_d = 6'd0;
                    a_d   = hash_in[255:224];
                    b_d   = hash_in[223:192];
                    c_d   = hash_in[191:160];
                    d_d   = hash_in[159:128];
                    e_d   = hash_in[127:96];
                    f_d   = hash_in[95:64];
                    g_d   = hash_in[63:32];
                    h_d   = hash_in[31:0];
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[511 - 32*i -: 32];
                    end
`ifdef SHA256_FEEDFWD_EN
                    hreg_d = hash_in;
`endif
                end
            end
            S_ROUND: begin
                a_d = t1 + t2;
                b_d = a_q;
                c_d = b_q;
                d_d = c_q;
                e_d = d_q + t1;
                f_d = e_q;
                g_d = f_q;
                h_d = g_q;
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i+1];
                end
                w_d[15] = w_next;
                rnd_d   = rnd_q + 6'd1;
            end
            S_FINAL: begin
`ifdef SHA256_FEEDFWD_EN
                digest_d = {a_q + hreg_q[255:224], b_q + hreg_q[223:192],
                            c_q + hreg_q[191:160], d_q + hreg_q[159:128],
                            e_q + hreg_q[127:96],  f_q + hreg_q[95:64],
                            g_q + hreg_q[63:32],   h_q + hreg_q[31:0]};
`else
                digest_d = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
`endif
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rnd_q    <= 6'd0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            e_q      <= '0;
            f_q      <= '0;
            g_q      <= '0;
            h_q      <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            digest_q <= '0;
            done_q   <= 1'b0;
`ifdef SHA256_FEEDFWD_EN
            hreg_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            e_q      <= e_d;
            f_q      <= f_d;
            g_q      <= g_d;
            h_q      <= h_d;
            w_q      <= w_d;
            digest_q <= digest_d;
            done_q   <= done_d;
`ifdef SHA256_FEEDFWD_EN
            hreg_q   <= hreg_d;
`endif
        end
    end

    // One-round lookahead on the ROM address; wraps to 0 on the last round.
    assign t      = (state_q == S_ROUND) ? rnd_q + 6'd1 : 6'd0;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign digest = digest_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: models the registered K ROM and checks against a textbook SHA-256 model.
module tb_sha256_compress;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic [31:0]  k_in;
    logic [5:0]   t;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int n_checks;
    int n_pass;
    logic [255:0] exp_q[$];

`ifdef SHA256_FEEDFWD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    sha256_compress dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .block_in (block_in),
        .hash_in  (hash_in),
        .k_in     (k_in),
        .t        (t),
        .busy     (busy),
        .done     (done),
        .digest   (digest)
    );

    // Clock / reset and the K ROM with its one-cycle read latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) k_in <= K_TAB[t];

    // Reference model: textbook SHA-256 compression with a fully expanded 64-word schedule.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin, input bit ff);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, ch, maj, tmp1, tmp2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
        for (int i = 0; i < 64; i++) begin
            s1   = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            ch   = (v[4] & v[5]) ^ (~v[4] & v[6]);
            tmp1 = v[7] + s1 + ch + K_TAB[i] + w[i];
            s0   = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            maj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            tmp2 = s0 + maj;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + tmp1;
            v[0] = tmp1 + tmp2;
        end
        for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = ff ? v[j] + hin[255 - 32*j -: 32] : v[j];
        return res;
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
        return r;
    endfunction

    function automatic logic [255:0] sub_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] - y[32*j +: 32];
        return r;
    endfunction

    // Known full-digest vector expressed in the form this build of the DUT produces.
    function automatic logic [255:0] build_form(input logic [255:0] full, input logic [255:0] hin);
        return FF ? full : sub_words(full, hin);
    endfunction

    // Driver: call at a negedge; returns at the negedge of the done cycle (or after a 200-cycle bound).
    task automatic run_block(input logic [511:0] blk, input logic [255:0] hin,
                             output logic [255:0] dig, output int lat);
        block_in = blk;
        hash_in  = hin;
        start    = 1'b1;
        lat      = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (done !== 1'b1 && lat < 200);
        dig = digest;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
        n_checks++; if (digest !== 256'h0) $display("FAIL reset_digest got=%h exp=0", digest); else n_pass++;
        n_checks++; if (t !== 6'd0) $display("FAIL reset_t got=%0d exp=0", t); else n_pass++;
    endtask

    task automatic test_abc();
        logic [255:0] dig;
        int lat;
        exp_q.push_back(build_form(ABC, IV));
        run_block(BLK_ABC, IV, dig, lat);
        n_checks++; if (lat !== 66) $display("FAIL abc_latency got=%0d exp=66", lat); else n_pass++;
        n_checks++; if (dig !== exp_q[0]) $display("FAIL abc_digest got=%h exp=%h", dig, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_empty();
        logic [255:0] dig;
        int lat;
        exp_q.push_back(build_form(EMPTY, IV));
        run_block(BLK_EMPTY, IV, dig, lat);
        n_checks++; if (lat !== 66) $display("FAIL empty_latency got=%0d exp=66", lat); else n_pass++;
        n_checks++; if (dig !== exp_q[0]) $display("FAIL empty_digest got=%h exp=%h", dig, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
    endtask

    // Second block starts in the first block's done cycle; chaining value formed as the controller would.
    task automatic test_back_to_back();
        logic [255:0] dig1, dig2, hin2;
        int lat1, lat2;
        run_block(BLK_TWO1, IV, dig1, lat1);
        hin2 = FF ? dig1 : add_words(dig1, IV);
        run_block(BLK_TWO2, hin2, dig2, lat2);
        n_checks++; if (lat1 !== 66) $display("FAIL two_lat1 got=%0d exp=66", lat1); else n_pass++;
        n_checks++; if (lat2 !== 66) $display("FAIL two_done_gap got=%0d exp=66", lat2); else n_pass++;
        n_checks++;
        if (build_form(TWO, hin2) !== dig2) $display("FAIL two_digest got=%h exp=%h", dig2, build_form(TWO, hin2));
        else n_pass++;
    endtask

    task automatic test_raw_plus_iv();
        logic [255:0] dig;
        int lat;
        run_block(BLK_ABC, IV, dig, lat);
        n_checks++;
        if ((FF ? dig : add_words(dig, IV)) !== ABC) $display("FAIL abc_chain got=%h exp=%h", dig, ABC);
        else n_pass++;
    endtask

    task automatic test_t_sequence();
        logic [255:0] exp_dig;
        int n_done;
        exp_dig = build_form(ABC, IV);
        @(negedge clk);
        n_checks++; if (t !== 6'd0) $display("FAIL t_idle got=%0d exp=0", t); else n_pass++;
        block_in = BLK_ABC;
        hash_in  = IV;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 66; cyc++) begin
            @(negedge clk);
            start = (cyc == 10 || cyc == 65);
            if (cyc == 10) begin
                for (int j = 0; j < 16; j++) block_in[32*j +: 32] = $urandom;
                hash_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            n_checks++;
            if (t !== ((cyc <= 64) ? 6'(cyc % 64) : 6'd0)) $display("FAIL t_seq cyc=%0d got=%0d", cyc, t);
            else n_pass++;
            n_checks++;
            if (busy !== (cyc <= 65)) $display("FAIL busy_seq cyc=%0d got=%0b", cyc, busy); else n_pass++;
            n_checks++;
            if (done !== (cyc == 66)) $display("FAIL done_seq cyc=%0d got=%0b", cyc, done); else n_pass++;
        end
        n_checks++; if (digest !== exp_dig) $display("FAIL t_seq_digest got=%h exp=%h", digest, exp_dig); else n_pass++;
        n_done = 0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++; if (n_done !== 0) $display("FAIL ignored_start got=%0d extra cycles exp=0", n_done); else n_pass++;
        n_checks++; if (digest !== exp_dig) $display("FAIL digest_hold got=%h exp=%h", digest, exp_dig); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [255:0] dig;
        int lat;
        block_in = BLK_ABC;
        hash_in  = IV;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%0b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got=%0b exp=0", done); else n_pass++;
        n_checks++; if (digest !== 256'h0) $display("FAIL midrst_digest got=%h exp=0", digest); else n_pass++;
        n_checks++; if (t !== 6'd0) $display("FAIL midrst_t got=%0d exp=0", t); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(build_form(ABC, IV));
        run_block(BLK_ABC, IV, dig, lat);
        n_checks++; if (lat !== 66) $display("FAIL midrst_latency got=%0d exp=66", lat); else n_pass++;
        n_checks++; if (dig !== exp_q[0]) $display("FAIL midrst_digest_after got=%h exp=%h", dig, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        logic [511:0] blk;
        logic [255:0] hin, dig, exp_dig;
        int lat;
        for (int n = 0; n < 8; n++) begin
            for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom;
            for (int j = 0; j < 8; j++) hin[32*j +: 32] = $urandom;
            exp_q.push_back(ref_compress(blk, hin, FF));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_block(blk, hin, dig, lat);
            exp_dig = exp_q.pop_front();
            n_checks++; if (lat !== 66) $display("FAIL rand_latency n=%0d got=%0d exp=66", n, lat); else n_pass++;
            n_checks++; if (dig !== exp_dig) $display("FAIL rand_digest n=%0d got=%h exp=%h", n, dig, exp_dig); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        block_in = '0;
        hash_in  = '0;
        test_reset();
        test_abc();
        test_empty();
        test_back_to_back();
        test_raw_plus_iv();
        test_t_sequence();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

Iterative SHA-256 compression engine that runs one 512-bit message block through 64 rounds, one round per clock. It sits directly downstream of `k_constant_rom`: it drives the ROM's `t` address and consumes its registered `k_out` as `k_in`. It holds the 16-word message-schedule window internally and returns the updated 256-bit chaining value to the padding/chaining controller above it.

## Interface
Parameters:
- None. All widths are fixed by SHA-256.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request to compress; accepted only while idle.
- `block_in` in 512: message block. Word 0 is `block_in[511:480]` (big-endian word order). Sampled on the accept cycle.
- `hash_in` in 256: incoming chaining value. H0 is `[255:224]`. Sampled on the accept cycle.
- `k_in` in 32: round constant from `k_constant_rom.k_out`, which has one-cycle read latency.
- `t` out 6: K ROM address, combinational from the round state.
- `busy` out 1: high from the cycle after accept through the FINAL cycle.
- `done` out 1: one-cycle pulse; `digest` is valid from this cycle on.
- `digest` out 256: result; holds its value until the next FINAL.

## Operation
- States: IDLE, ROUND, FINAL.
  - IDLE to ROUND on `start`.
  - ROUND to FINAL when `rnd` equals 63.
  - FINAL to IDLE unconditionally.
- Accept (IDLE with `start` high):
  - a..h load from `hash_in`.
  - `hash_in` is copied to an internal H register.
  - The W window W[0..15] loads from `block_in`.
  - `rnd` clears to 0.
- ROUND r (`rnd` = r):
  - T1 = h + Σ1(e) + Ch(e,f,g) + `k_in` + W[0]
  - T2 = Σ0(a) + Maj(a,b,c)
  - Standard a..h update; all additions mod 2^32.
  - Window shifts down one word. The new W[15] = σ1(W[14]) + W[9] + σ0(W[1]) + W[0] mod 2^32.
  - `rnd` increments.
- Function definitions:
  - Σ0 = ROTR2 ^ ROTR13 ^ ROTR22
  - Σ1 = ROTR6 ^ ROTR11 ^ ROTR25
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10
- FINAL: `digest` is registered (see Configuration). `done` is registered high for the following cycle.
- `t` drive:
  - In ROUND, `t` = (`rnd`+1) mod 64. This is a one-round lookahead that compensates for the ROM latency, so `t` wraps to 0 at r=63.
  - In all other states, `t` = 0, so that `k_in` = K[0] on the first ROUND cycle.
- `start` while `busy` is ignored; no queuing.
- `start` in the `done` cycle (state IDLE) is accepted normally.
- Reset, including mid-operation, forces:
  - state IDLE, `rnd` 0
  - `busy` 0, `done` 0
  - `digest` 0, `t` 0
  - a..h, H and W cleared

## Timing
- Accept at cycle 0.
- ROUND occupies cycles 1–64.
- FINAL is cycle 65.
- `done` is high in cycle 66, with `digest` valid.
- Throughput: one block per 66 cycles back-to-back (start again in the `done` cycle).
- `busy` is high in cycles 1–65.
- At cycle N in ROUND, the ROM presents K[`t` of cycle N−1], which equals K[`rnd`]. Verify this alignment explicitly.

## Configuration
- `SHA256_FEEDFWD_EN` defined:
  - FINAL computes `digest` = {a+H0, …, h+H7}, each word mod 2^32.
  - This is the full SHA-256 compression result.
- `SHA256_FEEDFWD_EN` undefined:
  - The eight feed-forward adders and the H register are omitted.
  - `digest` = {a..h} raw; the upstream controller performs the addition.
  - `hash_in` is still used to initialise a..h.
  - Timing is unchanged.

## Test plan
Except for scenario 4, all scenarios run with `SHA256_FEEDFWD_EN` defined, `hash_in` = the standard IV 6a09e667…5be0cd19, and the real `k_constant_rom` attached.

1. "abc" padded block (61626380, zeros, final word 00000018) -> `done` at cycle 66 with `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Empty message (80000000, remaining words 0) -> `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
3. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second start issued in the `done` cycle with `hash_in` = first `digest` -> final `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Second `done` exactly 66 cycles after the first.
4. Macro undefined, "abc" block -> `digest` + IV (per word, mod 2^32) equals the scenario 1 digest.
5. Monitor `t` through one block -> `t` = 0 when idle, then 1,2,…,63,0 across cycles 1–64, then 0. `start` pulses in cycles 10 and 65 are ignored: a single `done`, result unchanged.
6. Assert `rst` at cycle 30 of a block -> immediately `busy`=0, `done`=0, `digest`=0, `t`=0. A fresh "abc" start afterwards yields the scenario 1 digest.
